mmio_host_sequencer: RTL and testbench

On-chip MMIO initiator that programs and runs the ring-oscillator sampling AFU's register map without software. On `start` it writes the four configuration registers, reads one back for verification, pulses go, then polls done at a fixed interval until completion or timeout. It drives the same MMIO write/read signals the host would, so the AFU's register block needs no changes when driven from this sequencer (self-test builds and simulation benches).

---
 rtl/mmio_host_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_mmio_host_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_sequencer.sv
// mmio_host_sequencer: on-chip MMIO initiator for the ring-oscillator sampling AFU.
// On start it writes the four configuration registers, reads num_samples back to
// verify it, writes go, then polls the done register every POLL_GAP idle cycles
// until done is seen or MAX_POLLS reads have been issued. All outputs are registered
// and are decoded from the next state, so each state's strobe appears in the cycle
// the FSM occupies that state.
module mmio_host_sequencer #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 32,
  parameter int POLL_GAP   = 16,
  parameter int MAX_POLLS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [SIZE_WIDTH-1:0] cfg_num_samples,
  input  logic [SIZE_WIDTH-1:0] cfg_collect_cycles,
  output logic                  mmio_wr_en,
  output logic [15:0]           mmio_wr_addr,
  output logic [63:0]           mmio_wr_data,
  output logic                  mmio_rd_en,
  output logic [15:0]           mmio_rd_addr,
  input  logic [63:0]           mmio_rd_data,
  output logic                  busy,
  output logic                  finish,
  output logic [1:0]            status
);

  localparam int PCNT_W = $clog2(MAX_POLLS + 1);
  localparam int GCNT_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [PCNT_W-1:0] POLL_LIMIT = PCNT_W'(MAX_POLLS);
  localparam logic [GCNT_W-1:0] GAP_LAST   = GCNT_W'(POLL_GAP - 1);

  localparam logic [15:0] REG_GO   = 16'h0050;
  localparam logic [15:0] REG_RD   = 16'h0052;
  localparam logic [15:0] REG_WR   = 16'h0054;
  localparam logic [15:0] REG_NUM  = 16'h0056;
  localparam logic [15:0] REG_CYC  = 16'h0058;
  localparam logic [15:0] REG_DONE = 16'h0060;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_VERIFY  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_W_RD  = 4'd1,
    S_W_WR  = 4'd2,
    S_W_NUM = 4'd3,
    S_W_CYC = 4'd4,
    S_VRD   = 4'd5,
    S_VCHK  = 4'd6,
    S_W_GO  = 4'd7,
    S_PRD   = 4'd8,
    S_PCHK  = 4'd9,
    S_GAP   = 4'd10,
    S_END   = 4'd11
  } state_e;

  state_e                state_q, state_d;
  logic [PCNT_W-1:0]     poll_q, poll_d;
  logic [GCNT_W-1:0]     gap_q, gap_d;
  logic [ADDR_WIDTH-1:0] cfg_rd_q, cfg_rd_d;
  logic [ADDR_WIDTH-1:0] cfg_wr_q, cfg_wr_d;
  logic [SIZE_WIDTH-1:0] cfg_num_q, cfg_num_d;
  logic [SIZE_WIDTH-1:0] cfg_cyc_q, cfg_cyc_d;
  logic [1:0]            status_q, status_d;
  logic                  wr_en_q, wr_en_d;
  logic [15:0]           wr_addr_q, wr_addr_d;
  logic [63:0]           wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [15:0]           rd_addr_q, rd_addr_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;

  // Only the low SIZE_WIDTH bits of read data carry meaning; the rest are dropped.
  if (SIZE_WIDTH < 64) begin : g_rd_hi
    logic unused_rd_hi_s;
    assign unused_rd_hi_s = ^mmio_rd_data[63:SIZE_WIDTH];
  end

  // Next-state, counter, capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    cfg_rd_d  = cfg_rd_q;
    cfg_wr_d  = cfg_wr_q;
    cfg_num_d = cfg_num_q;
    cfg_cyc_d = cfg_cyc_q;
    status_d  = status_q;
    wr_en_d   = 1'b0;
    wr_addr_d = 16'h0000;
    wr_data_d = 64'h0;
    rd_en_d   = 1'b0;
    rd_addr_d = 16'h0000;
    finish_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_W_RD;
          cfg_rd_d  = cfg_rd_addr;
          cfg_wr_d  = cfg_wr_addr;
          cfg_num_d = cfg_num_samples;
          cfg_cyc_d = cfg_collect_cycles;
          poll_d    = '0;
          gap_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_RD:  state_d = S_W_WR;
      S_W_WR:  state_d = S_W_NUM;
      S_W_NUM: state_d = S_W_CYC;
      S_W_CYC: state_d = S_VRD;
      S_VRD:   state_d = S_VCHK;
      S_VCHK: begin
        if (mmio_rd_data[SIZE_WIDTH-1:0] != cfg_num_q) begin
          state_d  = S_END;
          status_d = ST_VERIFY;
        end else begin
          state_d = S_W_GO;
        end
      end
      S_W_GO: state_d = S_PRD;
      S_PRD: begin
        state_d = S_PCHK;
        // Saturate rather than wrap so a stuck count can never look fresh.
        if (poll_q != POLL_LIMIT) begin
          poll_d = poll_q + PCNT_W'(1);
        end else begin
          poll_d = poll_q;
        end
      end
      S_PCHK: begin
        if (mmio_rd_data[0]) begin
          state_d  = S_END;
          status_d = ST_OK;
        end else if (poll_q == POLL_LIMIT) begin
          state_d  = S_END;
          status_d = ST_TIMEOUT;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_PRD;
        end else begin
          gap_d = gap_q + GCNT_W'(1);
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the state being entered; a low strobe keeps address/data at zero.
    case (state_d)
      S_W_RD:  begin wr_en_d = 1'b1; wr_addr_d = REG_RD;  wr_data_d = 64'(cfg_rd_d);  end
      S_W_WR:  begin wr_en_d = 1'b1; wr_addr_d = REG_WR;  wr_data_d = 64'(cfg_wr_d);  end
      S_W_NUM: begin wr_en_d = 1'b1; wr_addr_d = REG_NUM; wr_data_d = 64'(cfg_num_d); end
      S_W_CYC: begin wr_en_d = 1'b1; wr_addr_d = REG_CYC; wr_data_d = 64'(cfg_cyc_d); end
      S_VRD:   begin rd_en_d = 1'b1; rd_addr_d = REG_NUM; end
      S_W_GO:  begin wr_en_d = 1'b1; wr_addr_d = REG_GO;  wr_data_d = 64'd1; end
      S_PRD:   begin rd_en_d = 1'b1; rd_addr_d = REG_DONE; end
      S_END:   finish_d = 1'b1;
      default: finish_d = 1'b0;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_END);
  end

  // State, counters, captured configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      poll_q    <= '0;
      gap_q     <= '0;
      cfg_rd_q  <= '0;
      cfg_wr_q  <= '0;
      cfg_num_q <= '0;
      cfg_cyc_q <= '0;
      status_q  <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 64'h0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 16'h0000;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      gap_q     <= gap_d;
      cfg_rd_q  <= cfg_rd_d;
      cfg_wr_q  <= cfg_wr_d;
      cfg_num_q <= cfg_num_d;
      cfg_cyc_q <= cfg_cyc_d;
      status_q  <= status_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
    end
  end

  assign mmio_wr_en   = wr_en_q;
  assign mmio_wr_addr = wr_addr_q;
  assign mmio_wr_data = wr_data_q;
  assign mmio_rd_en   = rd_en_q;
  assign mmio_rd_addr = rd_addr_q;
  assign busy         = busy_q;
  assign finish       = finish_q;
  assign status       = status_q;

endmodule

// File: tb/tb_mmio_host_sequencer.sv
// Bench for mmio_host_sequencer: two instances (default parameters, and a short
// MAX_POLLS=4 / POLL_GAP=2 build), a small AFU register model answering reads,
// and a scoreboard of expected MMIO transactions and finish cycle/status.
module tb_mmio_host_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s[2];
  logic        start_s[2];
  logic [63:0] cra_s[2];
  logic [63:0] cwa_s[2];
  logic [31:0] cns_s[2];
  logic [31:0] ccc_s[2];
  logic        wr_en_s[2];
  logic [15:0] wr_addr_s[2];
  logic [63:0] wr_data_s[2];
  logic        rd_en_s[2];
  logic [15:0] rd_addr_s[2];
  logic [63:0] rd_data_s[2];
  logic        busy_s[2];
  logic        fin_s[2];
  logic [1:0]  status_s[2];

  mmio_host_sequencer u_dut (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]),
    .cfg_rd_addr(cra_s[0]), .cfg_wr_addr(cwa_s[0]),
    .cfg_num_samples(cns_s[0]), .cfg_collect_cycles(ccc_s[0]),
    .mmio_wr_en(wr_en_s[0]), .mmio_wr_addr(wr_addr_s[0]), .mmio_wr_data(wr_data_s[0]),
    .mmio_rd_en(rd_en_s[0]), .mmio_rd_addr(rd_addr_s[0]), .mmio_rd_data(rd_data_s[0]),
    .busy(busy_s[0]), .finish(fin_s[0]), .status(status_s[0])
  );

  mmio_host_sequencer #(.POLL_GAP(2), .MAX_POLLS(4)) u_dut_short (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]),
    .cfg_rd_addr(cra_s[1]), .cfg_wr_addr(cwa_s[1]),
    .cfg_num_samples(cns_s[1]), .cfg_collect_cycles(ccc_s[1]),
    .mmio_wr_en(wr_en_s[1]), .mmio_wr_addr(wr_addr_s[1]), .mmio_wr_data(wr_data_s[1]),
    .mmio_rd_en(rd_en_s[1]), .mmio_rd_addr(rd_addr_s[1]), .mmio_rd_data(rd_data_s[1]),
    .busy(busy_s[1]), .finish(fin_s[1]), .status(status_s[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected transactions: {is_read, addr, data}; reads carry zero data.
  logic [80:0] exp_q[2][$];
  int          fin_cyc_q[2][$];
  logic [1:0]  fin_st_q[2][$];

  // Register model configuration, written only by the stimulus process.
  bit fault_m[2];
  int done_at_m[2];
  logic [31:0] num_m[2];
  int pcnt_m[2];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle counter; after the edge that samples start (cyc==T before it), cyc reads T+1.
  always @(posedge clk) cyc <= cyc + 1;

  // AFU register model: read data valid exactly one cycle after the read strobe,
  // garbage otherwise (bit 0 low so it never fakes done).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en_s[d] && wr_addr_s[d] == 16'h0056) num_m[d] <= wr_data_s[d][31:0];
      if (wr_en_s[d] && wr_addr_s[d] == 16'h0052) pcnt_m[d] <= 0;
      if (rd_en_s[d] && rd_addr_s[d] == 16'h0056) begin
        rd_data_s[d] <= {32'h0, num_m[d] ^ 32'(fault_m[d])};
      end else if (rd_en_s[d] && rd_addr_s[d] == 16'h0060) begin
        pcnt_m[d]    <= pcnt_m[d] + 1;
        rd_data_s[d] <= {63'h0, (done_at_m[d] != 0) && (pcnt_m[d] + 1 >= done_at_m[d])};
      end else begin
        rd_data_s[d] <= 64'hFFFF_FFFF_FFFF_FFFE;
      end
    end
  end

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [80:0] got;
    for (int d = 0; d < 2; d++) begin
      if (wr_en_s[d] || rd_en_s[d]) begin
        check_eq($sformatf("one_strobe%0d", d), 128'(wr_en_s[d] & rd_en_s[d]), 128'd0);
        check_eq($sformatf("txn_expected%0d", d), 128'(exp_q[d].size() != 0), 128'd1);
        if (exp_q[d].size() != 0) begin
          got = wr_en_s[d] ? {1'b0, wr_addr_s[d], wr_data_s[d]} : {1'b1, rd_addr_s[d], 64'h0};
          check_eq($sformatf("txn%0d", d), 128'(got), 128'(exp_q[d].pop_front()));
        end
      end
      if (!wr_en_s[d]) check_eq($sformatf("wr_idle_zero%0d", d), {48'h0, wr_addr_s[d], wr_data_s[d]}, 128'd0);
      if (!rd_en_s[d]) check_eq($sformatf("rd_idle_zero%0d", d), 128'(rd_addr_s[d]), 128'd0);
      if (fin_s[d]) begin
        check_eq($sformatf("fin_expected%0d", d), 128'(fin_cyc_q[d].size() != 0), 128'd1);
        check_eq($sformatf("busy_at_fin%0d", d), 128'(busy_s[d]), 128'd0);
        if (fin_cyc_q[d].size() != 0) begin
          check_eq($sformatf("fin_cycle%0d", d), 128'(cyc), 128'(fin_cyc_q[d].pop_front()));
          check_eq($sformatf("fin_status%0d", d), 128'(status_s[d]), 128'(fin_st_q[d].pop_front()));
        end
      end
    end
  end

  // Called at a falling edge: queue expectations and pulse start for one cycle.
  task automatic launch(input int d, input logic [63:0] ra, input logic [63:0] wa,
                        input logic [31:0] ns, input logic [31:0] cc, input bit flt,
                        input int done_at, input int npolls, input int fin_off,
                        input logic [1:0] st);
    int t0;
    cra_s[d] = ra;
    cwa_s[d] = wa;
    cns_s[d] = ns;
    ccc_s[d] = cc;
    fault_m[d] = flt;
    done_at_m[d] = done_at;
    t0 = cyc;
    exp_q[d].push_back({1'b0, 16'h0052, ra});
    exp_q[d].push_back({1'b0, 16'h0054, wa});
    exp_q[d].push_back({1'b0, 16'h0056, 32'h0, ns});
    exp_q[d].push_back({1'b0, 16'h0058, 32'h0, cc});
    exp_q[d].push_back({1'b1, 16'h0056, 64'h0});
    if (!flt) begin
      exp_q[d].push_back({1'b0, 16'h0050, 64'h1});
      for (int i = 0; i < npolls; i++) exp_q[d].push_back({1'b1, 16'h0060, 64'h0});
    end
    if (fin_off > 0) begin
      fin_cyc_q[d].push_back(t0 + fin_off);
      fin_st_q[d].push_back(st);
    end
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    check_eq($sformatf("busy_rise%0d", d), 128'(busy_s[d]), 128'd1);
  endtask

  task automatic wait_fin(input int d, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (fin_s[d]) seen = 1'b1;
    end
    check_eq($sformatf("fin_seen%0d", d), 128'(seen), 128'd1);
  endtask

  function automatic logic [127:0] outs(input int d);
    return {29'h0, wr_en_s[d], wr_addr_s[d], wr_data_s[d], rd_en_s[d], rd_addr_s[d],
            busy_s[d], fin_s[d], status_s[d]};
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1;
      start_s[d] = 1'b0;
      cra_s[d] = 64'h0;
      cwa_s[d] = 64'h0;
      cns_s[d] = 32'h0;
      ccc_s[d] = 32'h0;
      fault_m[d] = 1'b0;
      done_at_m[d] = 0;
    end
    start_s[0] = 1'b1;  // start together with rst: reset must win
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check_eq($sformatf("reset_outs%0d", d), outs(d), 128'd0);
    start_s[0] = 1'b0;
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal: done on the third poll, finish at T+46.
    launch(0, 64'h1000, 64'h2000, 32'd8, 32'd100, 1'b0, 3, 3, 46, 2'd0);
    wait_fin(0, 100);
    repeat (40) @(negedge clk);

    // Verify fault: finish at T+7 with status 1 and never a go write.
    launch(0, 64'h3000, 64'h4000, 32'h55, 32'h10, 1'b1, 0, 0, 7, 2'd1);
    wait_fin(0, 30);
    repeat (60) @(negedge clk);
    check_eq("status_hold_idle", 128'(status_s[0]), 128'd1);

    // Start while busy with changed cfg: no restart, original values written.
    launch(0, 64'h5000, 64'h6000, 32'd16, 32'd200, 1'b0, 1, 1, 10, 2'd0);
    @(negedge clk);
    start_s[0] = 1'b1;
    cra_s[0] = 64'hAAAA;
    cwa_s[0] = 64'hBBBB;
    cns_s[0] = 32'd99;
    ccc_s[0] = 32'd77;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_fin(0, 40);
    repeat (30) @(negedge clk);

    // Reset during GAP (T+12): outputs clear next cycle, later start restarts cleanly.
    launch(0, 64'h7000, 64'h8000, 32'd4, 32'd5, 1'b0, 0, 1, 0, 2'd0);
    repeat (11) @(negedge clk);
    rst_s[0] = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_outs", outs(0), 128'd0);
    check_eq("rst_mid_pending", 128'(exp_q[0].size()), 128'd0);
    rst_s[0] = 1'b0;
    exp_q[0].delete();
    repeat (5) @(negedge clk);
    launch(0, 64'h9000, 64'hA000, 32'd12, 32'd13, 1'b0, 1, 1, 10, 2'd0);
    wait_fin(0, 40);
    repeat (5) @(negedge clk);

    // Back-to-back: status 1 held through run 2 until its finish.
    launch(0, 64'hB000, 64'hC000, 32'd6, 32'd7, 1'b1, 0, 0, 7, 2'd1);
    wait_fin(0, 30);
    @(negedge clk);
    launch(0, 64'hD000, 64'hE000, 32'd20, 32'd21, 1'b0, 2, 2, 28, 2'd0);
    repeat (3) @(negedge clk);
    check_eq("status_held_run2", 128'(status_s[0]), 128'd1);
    wait_fin(0, 60);

    // Short build: timeout after exactly 4 polls, then back-to-back run whose
    // poll counter must restart (done on poll 2, finish T+14).
    launch(1, 64'h100, 64'h200, 32'd3, 32'd9, 1'b0, 0, 4, 22, 2'd2);
    wait_fin(1, 60);
    @(negedge clk);
    launch(1, 64'h300, 64'h400, 32'd5, 32'd11, 1'b0, 2, 2, 14, 2'd0);
    repeat (3) @(negedge clk);
    check_eq("status_held_timeout", 128'(status_s[1]), 128'd2);
    wait_fin(1, 40);

    repeat (20) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("txn_leftover%0d", d), 128'(exp_q[d].size()), 128'd0);
      check_eq($sformatf("fin_leftover%0d", d), 128'(fin_cyc_q[d].size()), 128'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
